// File: rtl/hazard_if.sv
// Flush/hold control bundle between the pipeline datapath and the hazard unit.
// The slave side is the hazard unit; the master side is the pipeline that feeds it.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_memRead;
  logic             ex_mem_branch_taken;
  logic             ex_mem_mem_access;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             mem_timeout;

  modport master (
    output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
           id_ex_memRead, ex_mem_branch_taken, ex_mem_mem_access, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
           id_ex_memRead, ex_mem_branch_taken, ex_mem_mem_access, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage core: freezes on data-memory waits, flushes on
// taken branches, bubbles on load-use, and keeps stall/flush counters plus a timeout flag.
module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   rst_n,
  hazard_if.slave hz
);

  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              timeout_q, timeout_d;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic branch;
  logic stall_inc;

  assign mem_wait  = hz.ex_mem_mem_access & ~hz.dmem_ready;
  assign rs1_hit   = hz.id_uses_rs1 & (hz.if_id_rs1 == hz.id_ex_rd);
  assign rs2_hit   = hz.id_uses_rs2 & (hz.if_id_rs2 == hz.id_ex_rd);
  assign load_use  = hz.id_ex_memRead & (hz.id_ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign branch    = hz.ex_mem_branch_taken & ~mem_wait;
  // A taken branch squashes the dependent instruction, so its load-use is not a stall.
  assign stall_inc = mem_wait | (load_use & ~hz.ex_mem_branch_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:      if (mem_wait)  state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (!mem_wait) state_d = S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  // wait_cnt holds the number of consecutive wait cycles completed; it restarts on entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (mem_wait) begin
      if (state_q == S_RUN) begin
        wait_cnt_d = WAIT_W'(1);
      end else if (!(&wait_cnt_q)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    timeout_d = timeout_q | (mem_wait & (wait_cnt_d >= WAIT_W'(TIMEOUT)));
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
    if (branch && !(&flush_q)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  // Stage controls are purely combinational so they act on the edge the registers sample.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.id_ex_write  = 1'b1;
    hz.ex_mem_write = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.mem_wb_flush = 1'b0;
    if (!rst_n) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
      hz.mem_wb_flush = 1'b1;
    end else if (mem_wait) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.mem_wb_flush = 1'b1;
    end else if (branch) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_flush  = 1'b1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit, built with CNT_W=4 and TIMEOUT=8 so that
// saturation and timeout are reachable in a few cycles.
module tb_hazard_unit;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
  localparam logic [7:0] CTRL_RUN   = 8'b1111_0000;
  localparam logic [7:0] CTRL_RESET = 8'b0000_1111;
  localparam logic [7:0] CTRL_LU    = 8'b0011_0100;
  localparam logic [7:0] CTRL_BR    = 8'b1111_1110;
  localparam logic [7:0] CTRL_WAIT  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nVec = 0;
  int   nMis = 0;
  logic [7:0] ctrl;

  hazard_if #(.CNT_W(4)) hzIf ();

  hazard_unit #(.CNT_W(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hzIf)
  );

  assign ctrl = {hzIf.pc_write, hzIf.if_id_write, hzIf.id_ex_write, hzIf.ex_mem_write,
                 hzIf.if_id_flush, hzIf.id_ex_flush, hzIf.ex_mem_flush, hzIf.mem_wb_flush};

  always #5 clk = ~clk;

  task automatic idleInputs();
    hzIf.if_id_rs1           = 5'd0;
    hzIf.if_id_rs2           = 5'd0;
    hzIf.id_uses_rs1         = 1'b0;
    hzIf.id_uses_rs2         = 1'b0;
    hzIf.id_ex_rd            = 5'd0;
    hzIf.id_ex_memRead       = 1'b0;
    hzIf.ex_mem_branch_taken = 1'b0;
    hzIf.ex_mem_mem_access   = 1'b0;
    hzIf.dmem_ready          = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called at edge+1; releases reset at edge+3, well before the next edge.
  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic setLoadUse();
    hzIf.id_ex_memRead = 1'b1;
    hzIf.id_ex_rd      = 5'd5;
    hzIf.if_id_rs2     = 5'd5;
    hzIf.id_uses_rs2   = 1'b1;
    hzIf.if_id_rs1     = 5'd3;
    hzIf.id_uses_rs1   = 1'b1;
  endtask

  task automatic test_reset();
    idleInputs();
    hzIf.ex_mem_branch_taken = 1'b1;
    #2;
    nVec++;
    if (ctrl !== CTRL_RESET) begin
      nMis++; $display("[TB] FAIL resetCtrl: got %b expected %b", ctrl, CTRL_RESET);
    end
    nVec++;
    if (hzIf.stall_cycles !== 4'd0 || hzIf.flush_events !== 4'd0 || hzIf.mem_timeout !== 1'b0) begin
      nMis++; $display("[TB] FAIL resetRegs: got stall=%0d flush=%0d to=%b expected 0 0 0",
                       hzIf.stall_cycles, hzIf.flush_events, hzIf.mem_timeout);
    end
    idleInputs();
    rst_n = 1'b1;
    nextCycle();
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL runAfterReset: got %b expected %b", ctrl, CTRL_RUN);
    end
  endtask

  task automatic test_load_use();
    nextCycle(); idleInputs(); pulseReset();
    setLoadUse();
    #1;
    nVec++;
    if (ctrl !== CTRL_LU) begin
      nMis++; $display("[TB] FAIL loadUseCtrl: got %b expected %b", ctrl, CTRL_LU);
    end
    nextCycle();
    nVec++;
    if (hzIf.stall_cycles !== 4'd1) begin
      nMis++; $display("[TB] FAIL loadUseStall: got %0d expected 1", hzIf.stall_cycles);
    end
    idleInputs();
    #1;
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL loadUseClears: got %b expected %b", ctrl, CTRL_RUN);
    end
    nextCycle();
    hzIf.id_ex_memRead = 1'b1;
    hzIf.id_ex_rd      = 5'd0;
    hzIf.id_uses_rs1   = 1'b1;
    hzIf.id_uses_rs2   = 1'b1;
    #1;
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL rdZeroCtrl: got %b expected %b", ctrl, CTRL_RUN);
    end
    nextCycle();
    nVec++;
    if (hzIf.stall_cycles !== 4'd1) begin
      nMis++; $display("[TB] FAIL rdZeroStall: got %0d expected 1", hzIf.stall_cycles);
    end
    hzIf.id_ex_rd    = 5'd9;
    hzIf.if_id_rs1   = 5'd9;
    hzIf.id_uses_rs1 = 1'b0;
    hzIf.if_id_rs2   = 5'd4;
    #1;
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL rs1Unused: got %b expected %b", ctrl, CTRL_RUN);
    end
    hzIf.id_uses_rs1 = 1'b1;
    #1;
    nVec++;
    if (ctrl !== CTRL_LU) begin
      nMis++; $display("[TB] FAIL rs1Hit: got %b expected %b", ctrl, CTRL_LU);
    end
    nextCycle();
    nVec++;
    if (hzIf.stall_cycles !== 4'd2) begin
      nMis++; $display("[TB] FAIL rs1HitStall: got %0d expected 2", hzIf.stall_cycles);
    end
    idleInputs();
  endtask

  task automatic test_branch();
    nextCycle(); idleInputs(); pulseReset();
    hzIf.ex_mem_branch_taken = 1'b1;
    #1;
    nVec++;
    if (ctrl !== CTRL_BR) begin
      nMis++; $display("[TB] FAIL branchCtrl: got %b expected %b", ctrl, CTRL_BR);
    end
    nextCycle();
    nVec++;
    if (hzIf.flush_events !== 4'd1) begin
      nMis++; $display("[TB] FAIL branchCount: got %0d expected 1", hzIf.flush_events);
    end
    setLoadUse();
    #1;
    nVec++;
    if (ctrl !== CTRL_BR) begin
      nMis++; $display("[TB] FAIL branchOverLoadUse: got %b expected %b", ctrl, CTRL_BR);
    end
    nextCycle();
    nVec++;
    if (hzIf.flush_events !== 4'd2 || hzIf.stall_cycles !== 4'd0) begin
      nMis++; $display("[TB] FAIL branchLuCounters: got flush=%0d stall=%0d expected 2 0",
                       hzIf.flush_events, hzIf.stall_cycles);
    end
    idleInputs();
  endtask

  task automatic test_mem_wait();
    nextCycle(); idleInputs(); pulseReset();
    hzIf.ex_mem_mem_access   = 1'b1;
    hzIf.dmem_ready          = 1'b0;
    hzIf.ex_mem_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nVec++;
      if (ctrl !== CTRL_WAIT) begin
        nMis++; $display("[TB] FAIL waitCtrl[%0d]: got %b expected %b", i, ctrl, CTRL_WAIT);
      end
      nextCycle();
    end
    nVec++;
    if (hzIf.stall_cycles !== 4'd4 || hzIf.flush_events !== 4'd0) begin
      nMis++; $display("[TB] FAIL waitCounters: got stall=%0d flush=%0d expected 4 0",
                       hzIf.stall_cycles, hzIf.flush_events);
    end
    hzIf.dmem_ready = 1'b1;
    #1;
    nVec++;
    if (ctrl !== CTRL_BR) begin
      nMis++; $display("[TB] FAIL branchAfterWait: got %b expected %b", ctrl, CTRL_BR);
    end
    nextCycle();
    nVec++;
    if (hzIf.stall_cycles !== 4'd4 || hzIf.flush_events !== 4'd1) begin
      nMis++; $display("[TB] FAIL afterWaitCounters: got stall=%0d flush=%0d expected 4 1",
                       hzIf.stall_cycles, hzIf.flush_events);
    end
    idleInputs();
  endtask

  task automatic test_timeout();
    nextCycle(); idleInputs(); pulseReset();
    hzIf.ex_mem_mem_access = 1'b1;
    hzIf.dmem_ready        = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      nextCycle();
      nVec++;
      if (hzIf.mem_timeout !== (k >= 8)) begin
        nMis++; $display("[TB] FAIL timeout[%0d]: got %b expected %b", k, hzIf.mem_timeout, (k >= 8));
      end
    end
    hzIf.dmem_ready = 1'b1;
    #1;
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL resumeAfterTimeout: got %b expected %b", ctrl, CTRL_RUN);
    end
    nextCycle();
    idleInputs();
    nextCycle();
    nVec++;
    if (hzIf.mem_timeout !== 1'b1 || hzIf.stall_cycles !== 4'd10) begin
      nMis++; $display("[TB] FAIL timeoutSticky: got to=%b stall=%0d expected 1 10",
                       hzIf.mem_timeout, hzIf.stall_cycles);
    end
    rst_n = 1'b0;
    #1;
    nVec++;
    if (hzIf.mem_timeout !== 1'b0) begin
      nMis++; $display("[TB] FAIL timeoutReset: got %b expected 0", hzIf.mem_timeout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    nextCycle(); idleInputs(); pulseReset();
    hzIf.ex_mem_mem_access = 1'b1;
    hzIf.dmem_ready        = 1'b0;
    for (int k = 0; k < 9; k++) nextCycle();
    nVec++;
    if (hzIf.mem_timeout !== 1'b1 || hzIf.stall_cycles !== 4'd9) begin
      nMis++; $display("[TB] FAIL preResetWait: got to=%b stall=%0d expected 1 9",
                       hzIf.mem_timeout, hzIf.stall_cycles);
    end
    #3;
    rst_n = 1'b0;
    #1;
    nVec++;
    if (ctrl !== CTRL_RESET) begin
      nMis++; $display("[TB] FAIL asyncResetCtrl: got %b expected %b", ctrl, CTRL_RESET);
    end
    nVec++;
    if (hzIf.stall_cycles !== 4'd0 || hzIf.flush_events !== 4'd0 || hzIf.mem_timeout !== 1'b0) begin
      nMis++; $display("[TB] FAIL asyncResetRegs: got stall=%0d flush=%0d to=%b expected 0 0 0",
                       hzIf.stall_cycles, hzIf.flush_events, hzIf.mem_timeout);
    end
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    nVec++;
    if (ctrl !== CTRL_RUN) begin
      nMis++; $display("[TB] FAIL runAfterAsync: got %b expected %b", ctrl, CTRL_RUN);
    end
    hzIf.ex_mem_branch_taken = 1'b1;
    nextCycle();
    nVec++;
    if (hzIf.flush_events !== 4'd1 || hzIf.mem_timeout !== 1'b0) begin
      nMis++; $display("[TB] FAIL decodeAfterAsync: got flush=%0d to=%b expected 1 0",
                       hzIf.flush_events, hzIf.mem_timeout);
    end
    idleInputs();
  endtask

  task automatic test_saturation();
    nextCycle(); idleInputs(); pulseReset();
    setLoadUse();
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      if (k == 14) begin
        nVec++;
        if (hzIf.stall_cycles !== 4'd14) begin
          nMis++; $display("[TB] FAIL stallCount14: got %0d expected 14", hzIf.stall_cycles);
        end
      end
    end
    nVec++;
    if (hzIf.stall_cycles !== 4'd15) begin
      nMis++; $display("[TB] FAIL stallSaturate: got %0d expected 15", hzIf.stall_cycles);
    end
    idleInputs();
    hzIf.ex_mem_branch_taken = 1'b1;
    for (int k = 0; k < 18; k++) nextCycle();
    nVec++;
    if (hzIf.flush_events !== 4'd15 || hzIf.stall_cycles !== 4'd15) begin
      nMis++; $display("[TB] FAIL flushSaturate: got flush=%0d stall=%0d expected 15 15",
                       hzIf.flush_events, hzIf.stall_cycles);
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
